quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_pkg.sv | 41 ++++
 rtl/quad_filter.sv | 44 ++++
 rtl/quad_decoder.sv | 73 +++++++
 tb/tb_quad_decoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared phase encodings, default sizes and the phase-transition classifier
// used by the quadrature decoder.
package quad_pkg;

    localparam int POS_W_DEF    = 8;
    localparam int FILT_LEN_DEF = 3;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [1:0] {
        TR_NONE = 2'd0,
        TR_FWD  = 2'd1,
        TR_REV  = 2'd2,
        TR_ILL  = 2'd3
    } trans_t;

    function automatic logic [1:0] fwd_next(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    // Any change that is neither one step forward nor one step back flips both bits.
    function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
        trans_t t;
        if (cur == prev)                t = TR_NONE;
        else if (fwd_next(prev) == cur) t = TR_FWD;
        else if (fwd_next(cur) == prev) t = TR_REV;
        else                            t = TR_ILL;
        return t;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchronizer followed by a consecutive-sample glitch filter for one
// quadrature channel.
module quad_filter
    import quad_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic arst_n,
    input  logic din,
    output logic dout
);

    localparam logic [3:0] CNT_TC = 4'(FILT_LEN - 1);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic [3:0] cnt;

    // Level flips on the FILT_LEN-th consecutive disagreeing sample.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= 4'd0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= 4'd0;
            end else if (cnt == CNT_TC) begin
                level <= sync2;
                cnt   <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign dout = level;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phase tracking, step/direction pulses,
// wrapping position counter and sticky illegal-transition flag.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int POS_W    = POS_W_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             en,
    input  logic             clr,
    input  logic             err_clr,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic             err
);

    logic       a_filt;
    logic       b_filt;
    logic [1:0] phase;
    logic [1:0] prev_phase;
    trans_t     trans;
    logic       fwd_ok;
    logic       rev_ok;

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk    (clk),
        .arst_n (arst_n),
        .din    (a_in),
        .dout   (a_filt)
    );

    quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk    (clk),
        .arst_n (arst_n),
        .din    (b_in),
        .dout   (b_filt)
    );

    assign phase  = {a_filt, b_filt};
    assign trans  = classify(prev_phase, phase);
    assign fwd_ok = en && (trans == TR_FWD);
    assign rev_ok = en && (trans == TR_REV);

    // Phase tracking and error detection ignore en so re-enable is glitch-free.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            prev_phase <= PH_00;
            step       <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
            pos        <= '0;
        end else begin
            prev_phase <= phase;
            step       <= fwd_ok || rev_ok;

            if (fwd_ok)      dir <= 1'b1;
            else if (rev_ok) dir <= 1'b0;

            if (trans == TR_ILL) err <= 1'b1;
            else if (err_clr)    err <= 1'b0;

            if (clr)         pos <= '0;
            else if (fwd_ok) pos <= pos + POS_W'(1);
            else if (rev_ok) pos <= pos - POS_W'(1);
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder at default parameters
// (POS_W=8, FILT_LEN=3, so accepted transitions show up 6 edges after drive).
module tb_quad_decoder;

    localparam int LAT = 6;

    logic       clk;
    logic       arst_n;
    logic       a_in;
    logic       b_in;
    logic       en;
    logic       clr;
    logic       err_clr;
    logic       step;
    logic       dir;
    logic [7:0] pos;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int step_cnt = 0;

    quad_decoder dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .a_in    (a_in),
        .b_in    (b_in),
        .en      (en),
        .clr     (clr),
        .err_clr (err_clr),
        .step    (step),
        .dir     (dir),
        .pos     (pos),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (step === 1'b1) step_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b);
        @(negedge clk);
        a_in = a;
        b_in = b;
    endtask

    // Edges from drive until step rises; 0 means it never did within the budget.
    task automatic measure(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 arst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic fwd_step(input string tag, input logic a, input logic b,
                            input logic [7:0] exp_pos);
        int lat;
        drive(a, b);
        measure(lat);
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_dir"}, dir, 1'b1);
        chk({tag, "_pos"}, pos, exp_pos);
        hold(10 - lat);
    endtask

    initial begin
        int lat;
        int base;

        arst_n  = 1'b0;
        a_in    = 1'b0;
        b_in    = 1'b0;
        en      = 1'b1;
        clr     = 1'b0;
        err_clr = 1'b0;
        #13;
        chk("rst_step", step, 0);
        chk("rst_dir",  dir,  0);
        chk("rst_pos",  pos,  0);
        chk("rst_err",  err,  0);
        @(negedge clk);
        arst_n = 1'b1;
        hold(8);

        // Forward sweep 00->01->11->10->00
        base = step_cnt;
        fwd_step("sweep1", 1'b0, 1'b1, 8'd1);
        fwd_step("sweep2", 1'b1, 1'b1, 8'd2);
        fwd_step("sweep3", 1'b1, 1'b0, 8'd3);
        fwd_step("sweep4", 1'b0, 1'b0, 8'd4);
        chk("sweep_steps", step_cnt - base, 4);
        chk("sweep_err", err, 0);

        // Reverse wrap from reset, then forward back to zero
        do_reset();
        hold(8);
        drive(1'b1, 1'b0);
        measure(lat);
        chk("rev_lat", lat, LAT);
        chk("rev_dir", dir, 0);
        chk("rev_pos", pos, 8'd255);
        hold(10 - lat);
        fwd_step("wrap", 1'b0, 1'b0, 8'd0);

        // Glitch rejection: 2-cycle pulses on a_in
        base = step_cnt;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0);
            @(negedge clk);
            drive(1'b0, 1'b0);
            @(negedge clk);
        end
        hold(10);
        chk("glitch_steps", step_cnt - base, 0);
        chk("glitch_err", err, 0);
        chk("glitch_pos", pos, 8'd0);

        // Illegal jump 00->11, then clear, then normal step 11->10
        base = step_cnt;
        drive(1'b1, 1'b1);
        hold(8);
        chk("ill_err", err, 1);
        chk("ill_steps", step_cnt - base, 0);
        chk("ill_pos", pos, 8'd0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("errclr_err", err, 0);
        fwd_step("post_ill", 1'b1, 1'b0, 8'd1);

        // clr wins over a same-cycle step
        drive(1'b0, 1'b0);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_step", step, 1);
        chk("clr_pos", pos, 8'd0);
        @(negedge clk);
        clr = 1'b0;
        hold(4);

        // Illegal detection wins over a same-cycle err_clr
        drive(1'b1, 1'b1);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("setwin_err", err, 1);
        @(negedge clk);
        @(negedge clk);
        err_clr = 1'b0;
        chk("setwin_clr", err, 0);
        hold(4);

        // en=0 across two reverse steps: pos and dir held, no error
        base = step_cnt;
        @(negedge clk);
        en = 1'b0;
        drive(1'b0, 1'b1);
        hold(10);
        drive(1'b0, 1'b0);
        hold(10);
        chk("dis_pos", pos, 8'd0);
        chk("dis_dir", dir, 1);
        chk("dis_steps", step_cnt - base, 0);
        @(negedge clk);
        en = 1'b1;
        hold(10);
        chk("reen_steps", step_cnt - base, 0);
        chk("reen_err", err, 0);
        fwd_step("reen", 1'b0, 1'b1, 8'd1);

        // Build pos=5, err=1, then async reset mid-filter
        drive(1'b1, 1'b1); hold(10);
        drive(1'b1, 1'b0); hold(10);
        drive(1'b0, 1'b0); hold(10);
        drive(1'b0, 1'b1); hold(10);
        chk("pre_pos", pos, 8'd5);
        drive(1'b1, 1'b0); hold(10);
        chk("pre_err", err, 1);
        drive(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_step", step, 0);
        chk("arst_dir",  dir,  0);
        chk("arst_pos",  pos,  0);
        chk("arst_err",  err,  0);
        a_in = 1'b0;
        b_in = 1'b1;
        @(negedge clk);
        arst_n = 1'b1;
        base = step_cnt;
        hold(LAT - 1);
        chk("release_quiet", step_cnt - base, 0);
        hold(1);
        chk("release_step", step, 1);
        chk("release_pos", pos, 8'd1);
        hold(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
